// File: rtl/mag_timer.sv
// rtl/mag_timer.sv - MM:SS BCD cook-time countdown with optional end-of-cook alarm (MAG_TIMER_ALARM_EN)
module mag_timer #(
  parameter int TICK_DIV    = 100,
  parameter int ALARM_TICKS = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       mag_on,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       alarm
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc;
  logic          count_zero;
  logic          key_ok;
  logic          alarm_run;
  logic          run;
  logic          tick;
  logic          dec;
  logic          dec_to_zero;
  logic [3:0]    n_mt, n_mo, n_st, n_so;

  assign count_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign timer_done = count_zero;

  // Keypad digits are only accepted while the magnetron is off and the digit is BCD.
  assign key_ok = key_valid && !mag_on && (key_digit <= 4'd9);

  // The prescaler advances while cooking a nonzero count, or while an alarm is sounding.
  assign run  = (mag_on && !count_zero) || alarm_run;
  assign tick = run && (presc == PW'(TICK_DIV - 1));
  assign dec  = tick && !count_zero;

  // BCD decrement with borrow; only used when the count is nonzero.
  always_comb begin
    n_mt = min_tens;
    n_mo = min_ones;
    n_st = sec_tens;
    n_so = sec_ones;
    if (sec_ones != 4'd0) begin
      n_so = sec_ones - 4'd1;
    end else begin
      n_so = 4'd9;
      if (sec_tens != 4'd0) begin
        n_st = sec_tens - 4'd1;
      end else begin
        n_st = 4'd5;
        if (min_ones != 4'd0) begin
          n_mo = min_ones - 4'd1;
        end else begin
          n_mo = 4'd9;
          n_mt = min_tens - 4'd1;
        end
      end
    end
  end

  assign dec_to_zero = (n_mt == 4'd0) && (n_mo == 4'd0) && (n_st == 4'd0) && (n_so == 4'd0);

  // Digit registers: reset/clear, then keypad shift-in, then tick decrement.
  always_ff @(posedge clk) begin
    if (!resetn || !clearn) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else if (key_ok) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= key_digit;
    end else if (dec) begin
      min_tens <= n_mt;
      min_ones <= n_mo;
      sec_tens <= n_st;
      sec_ones <= n_so;
    end
  end

  // One-second prescaler; holds when not running so a pause keeps the partial second.
  always_ff @(posedge clk) begin
    if (!resetn || !clearn) begin
      presc <= '0;
    end else if (key_ok) begin
      presc <= '0;
    end else if (run) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

`ifdef MAG_TIMER_ALARM_EN
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  logic          alarm_q;
  logic [AW-1:0] alarm_cnt;

  assign alarm_run = alarm_q;
  assign alarm     = alarm_q;

  // Alarm sounds for ALARM_TICKS ticks after counting down to zero; any key cancels it.
  always_ff @(posedge clk) begin
    if (!resetn || !clearn) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else if (key_valid) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else if (dec && dec_to_zero) begin
      alarm_q   <= 1'b1;
      alarm_cnt <= '0;
    end else if (alarm_q && tick) begin
      if (alarm_cnt == AW'(ALARM_TICKS - 1)) begin
        alarm_q   <= 1'b0;
        alarm_cnt <= '0;
      end else begin
        alarm_cnt <= alarm_cnt + AW'(1);
      end
    end
  end
`else
  logic unused_alarm;

  assign alarm_run    = 1'b0;
  assign alarm        = 1'b0;
  assign unused_alarm = dec_to_zero ^ (ALARM_TICKS != 0);
`endif

endmodule

// File: tb/tb_mag_timer.sv
// tb/tb_mag_timer.sv - self-checking bench for mag_timer against a seconds-level model
module tb_mag_timer;

  localparam int TICK_DIV    = 4;
  localparam int ALARM_TICKS = 2;
`ifdef MAG_TIMER_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn, clearn, mag_on, key_valid;
  logic [3:0] key_digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, alarm;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mag_timer #(.TICK_DIV(TICK_DIV), .ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk), .resetn(resetn), .clearn(clearn), .mag_on(mag_on),
    .key_valid(key_valid), .key_digit(key_digit),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .timer_done(timer_done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Model: minutes and seconds fields as plain integers, phase within the current second.
  int m_min = 0, m_sec = 0, m_phase = 0, m_alarm_left = 0;

  function automatic logic [15:0] model_digits();
    logic [15:0] r;
    r = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    return r;
  endfunction

  always @(posedge clk) begin
    int  total;
    bit  runs, tk;
    if (!resetn || !clearn) begin
      m_min = 0; m_sec = 0; m_phase = 0; m_alarm_left = 0;
    end else begin
      total = m_min * 60 + m_sec;
      tk = 1'b0;
      if (key_valid && !mag_on && key_digit <= 4'd9) begin
        m_min   = (m_min % 10) * 10 + (m_sec / 10);
        m_sec   = (m_sec % 10) * 10 + int'(key_digit);
        m_phase = 0;
      end else begin
        runs = (mag_on && total != 0) || (m_alarm_left > 0);
        if (runs) begin
          m_phase = m_phase + 1;
          if (m_phase == TICK_DIV) begin
            m_phase = 0;
            tk = 1'b1;
          end
        end
      end
      if (tk) begin
        if (total != 0) begin
          if (m_sec > 0) m_sec = m_sec - 1;
          else begin m_sec = 59; m_min = m_min - 1; end
          if (ALARM_EN && m_min == 0 && m_sec == 0) m_alarm_left = ALARM_TICKS;
        end else if (m_alarm_left > 0) begin
          m_alarm_left = m_alarm_left - 1;
        end
      end
      if (key_valid) m_alarm_left = 0;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [15:0] got, exp;
    logic        exp_done, exp_alarm;
    if (chk_en) begin
      got       = {min_tens, min_ones, sec_tens, sec_ones};
      exp       = model_digits();
      exp_done  = (m_min == 0) && (m_sec == 0);
      exp_alarm = (m_alarm_left > 0);
      checks++;
      if (got !== exp || timer_done !== exp_done || alarm !== exp_alarm) begin
        errors++;
        $display("FAIL model t=%0t digits=%h done=%b alarm=%b required digits=%h done=%b alarm=%b",
                 $time, got, timer_done, alarm, exp, exp_done, exp_alarm);
      end
    end
  end

  task automatic expect_lit(input string nm, input logic [15:0] d, input logic done, input logic al);
    logic [15:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones};
    checks++;
    if (got !== d || timer_done !== done || alarm !== al) begin
      errors++;
      $display("FAIL %s digits=%h done=%b alarm=%b required digits=%h done=%b alarm=%b",
               nm, got, timer_done, alarm, d, done, al);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge clk);
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    mag_on = 1'b0;
    clearn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
    key(a); key(b); key(c); key(d);
  endtask

  initial begin
    int al_cycles;
    resetn = 1'b0; clearn = 1'b1; mag_on = 1'b0; key_valid = 1'b0; key_digit = 4'd0;

    // Reset
    cycles(1);
    chk_en = 1'b1;
    cycles(1);
    expect_lit("reset", 16'h0000, 1'b1, 1'b0);
    resetn = 1'b1;

    // Entry
    key(4'd1); key(4'd3); key(4'd0);
    expect_lit("entry_130", 16'h0130, 1'b0, 1'b0);
    key(4'd11);
    expect_lit("entry_gt9", 16'h0130, 1'b0, 1'b0);
    mag_on = 1'b1;
    key(4'd5);
    expect_lit("entry_magon", 16'h0130, 1'b0, 1'b0);
    mag_on = 1'b0;

    // Borrow
    load(4'd0, 4'd1, 4'd0, 4'd0);
    expect_lit("load_0100", 16'h0100, 1'b0, 1'b0);
    mag_on = 1'b1;
    cycles(3);
    expect_lit("borrow_pre", 16'h0100, 1'b0, 1'b0);
    cycles(1);
    expect_lit("borrow_0059", 16'h0059, 1'b0, 1'b0);
    load(4'd1, 4'd0, 4'd0, 4'd0);
    mag_on = 1'b1;
    cycles(4);
    expect_lit("borrow_0959", 16'h0959, 1'b0, 1'b0);
    load(4'd0, 4'd0, 4'd9, 4'd9);
    mag_on = 1'b1;
    cycles(4);
    expect_lit("literal_0098", 16'h0098, 1'b0, 1'b0);

    // Pause / resume keeps the partial second
    load(4'd0, 4'd0, 4'd0, 4'd2);
    mag_on = 1'b1;
    cycles(2);
    mag_on = 1'b0;
    cycles(10);
    expect_lit("paused", 16'h0002, 1'b0, 1'b0);
    mag_on = 1'b1;
    cycles(1);
    expect_lit("resume_1", 16'h0002, 1'b0, 1'b0);
    cycles(1);
    expect_lit("resume_2", 16'h0001, 1'b0, 1'b0);

    // Done, then alarm duration
    load(4'd0, 4'd0, 4'd0, 4'd1);
    mag_on = 1'b1;
    cycles(4);
    expect_lit("done", 16'h0000, 1'b1, ALARM_EN);
    mag_on = 1'b0;
    al_cycles = 0;
    for (int i = 0; i < 14; i++) begin
      if (alarm) al_cycles++;
      @(negedge clk);
    end
    checks++;
    if (al_cycles != (ALARM_EN ? 8 : 0)) begin
      errors++;
      $display("FAIL alarm_len got=%0d required=%0d", al_cycles, ALARM_EN ? 8 : 0);
    end
    expect_lit("done_hold", 16'h0000, 1'b1, 1'b0);

    // Alarm cancelled by a key, even an out-of-range one
    load(4'd0, 4'd0, 4'd0, 4'd1);
    mag_on = 1'b1;
    cycles(4);
    mag_on = 1'b0;
    cycles(1);
    expect_lit("alarm_on", 16'h0000, 1'b1, ALARM_EN);
    key(4'd12);
    expect_lit("alarm_cancel", 16'h0000, 1'b1, 1'b0);

    // Clear mid-count wins over counting; no alarm from a clear
    load(4'd0, 4'd0, 4'd0, 4'd5);
    mag_on = 1'b1;
    cycles(3);
    clearn = 1'b0;
    cycles(1);
    clearn = 1'b1;
    expect_lit("clear", 16'h0000, 1'b1, 1'b0);
    cycles(6);
    expect_lit("clear_hold", 16'h0000, 1'b1, 1'b0);
    mag_on = 1'b0;

    // Reset mid-count leaves no residual prescaler phase
    load(4'd0, 4'd0, 4'd1, 4'd0);
    mag_on = 1'b1;
    cycles(3);
    resetn = 1'b0;
    cycles(1);
    resetn = 1'b1;
    expect_lit("reset_mid", 16'h0000, 1'b1, 1'b0);
    load(4'd0, 4'd0, 4'd0, 4'd1);
    mag_on = 1'b1;
    cycles(3);
    expect_lit("no_residual", 16'h0001, 1'b0, 1'b0);
    cycles(1);
    expect_lit("after_reset_tick", 16'h0000, 1'b1, ALARM_EN);
    mag_on = 1'b0;
    cycles(12);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_timer.md
# mag_timer

Countdown timer for the microwave controller, sitting directly upstream of the magnetron control stage. It holds the cook time as four BCD digits (MM:SS) entered from the keypad. It decrements once per second while the magnetron is on and asserts `timer_done` when the count is zero. The control stage consumes `timer_done` to reset its on/off latch, and its latch output comes back here as `mag_on`.

## Interface
Parameters:
- `TICK_DIV`, default 100: clock cycles per one-second tick; must be ≥ 2.
- `ALARM_TICKS`, default 3: alarm duration in ticks. Used only with `MAG_TIMER_ALARM_EN`.

Ports:
- `clk` in 1: system clock, rising edge.
- `resetn` in 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `clearn` in 1: synchronous, active-low clear of the time count.
- `mag_on` in 1: magnetron on (latch output of the control stage); enables counting.
- `key_valid` in 1: one-cycle strobe carrying a keypad digit.
- `key_digit` in 4: BCD digit 0–9.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each: registered BCD count.
- `timer_done` out 1: high when all four digits are 0.
- `alarm` out 1: end-of-cook alarm.

## Operation
- Priority per cycle: `resetn`=0 > `clearn`=0 > key entry > tick decrement.
- Reset:
  - digits = 0, prescaler = 0, `alarm` = 0.
  - `timer_done` = 1, because the count is zero.
- Clear (`clearn`=0):
  - digits = 0, prescaler = 0, alarm state cleared.
  - Honoured regardless of `mag_on`.
- Key entry: `key_valid`=1, `mag_on`=0 and `key_digit` ≤ 9.
  - Shift left: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`key_digit`.
  - Prescaler cleared.
  - Digits > 9 are ignored.
  - Entry while `mag_on`=1 is ignored.
  - `sec_tens` may hold 6–9 (e.g. 00:99). This counts down literally as 99 seconds; no normalisation.
- Prescaler:
  - Runs only while `mag_on`=1 and count ≠ 0.
  - Counts 0..`TICK_DIV`-1 and raises an internal `tick` when at `TICK_DIV`-1, then wraps to 0.
  - Holds its value when `mag_on` drops, so pause/resume keeps the partial second.
- Decrement on `tick`, BCD with borrow:
  - If `sec_ones` > 0, decrement it.
  - Otherwise `sec_ones` = 9 and borrow into `sec_tens`: decrement if > 0, else `sec_tens` = 5 and borrow into minutes.
  - Minute borrow: `min_ones` decrements, or wraps to 9 and `min_tens` decrements.
  - The count never decrements below 00:00, since ticks stop when the count is 0.
- `timer_done`:
  - Combinational equality-to-zero of the digit registers. No extra register.
  - It stays high while the count is 0. The control stage must not restart from 00:00.

## Timing
- A tick occurs `TICK_DIV` cycles after counting starts from prescaler 0.
- Digits update on the clock edge that samples `tick`.
- `timer_done` rises in that same cycle, once the registers read 0.
- Key entry is visible on the outputs one cycle after the `key_valid` edge.
- `clearn` and `resetn` take effect on the next edge and are fully synchronous.
- Simultaneous events:
  - `key_valid` and `tick` in the same cycle cannot both act, because the key is ignored while `mag_on`=1.
  - `clearn` together with `tick` → clear wins; result 00:00.
- Reset mid-count: all state returns to reset values on the next edge; no residual tick.

## Configuration
- `MAG_TIMER_ALARM_EN` defined:
  - On a decrement that reaches 00:00, `alarm` goes high the next cycle.
  - It stays high for exactly `ALARM_TICKS` ticks. The prescaler keeps running for the alarm even with `mag_on`=0.
  - `clearn`=0 or any `key_valid` cancels the alarm immediately.
  - A count reaching 0 through clear or reset never raises `alarm`.
- Not defined: `alarm` tied to 0 and no alarm logic is synthesised. `ALARM_TICKS` is ignored.

## Test plan
Bench uses `TICK_DIV`=4, `ALARM_TICKS`=2.
- Reset: hold `resetn`=0 for 2 cycles → digits 0000, `timer_done`=1, `alarm`=0.
- Entry: keys 1,3,0 with `mag_on`=0 → 01:30, `timer_done`=0. Key 11 → unchanged. Key 5 with `mag_on`=1 → unchanged.
- Borrow: load 01:00, `mag_on`=1 → after 4 cycles reads 00:59. Load 10:00 → after one tick reads 09:59.
- Pause/resume: load 00:02, `mag_on`=1 for 2 cycles, 0 for 10 cycles, then 1 → 00:01 appears exactly 2 cycles after resume.
- Done/clear: load 00:01, `mag_on`=1 → 00:00 and `timer_done`=1 after 4 cycles, digits stay 0. Then load 00:05, assert `clearn`=0 mid-count → 00:00 next edge.
- Alarm, with the macro defined: reach 00:00 by counting → `alarm` high for 8 cycles then low. With the macro undefined → `alarm` is 0 throughout.
